// File: rtl/udm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udm_pkg
// Description : Shared UDM constants, serializer state type and byte helpers
//               used by both the UDM response transmitter and the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package udm_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam logic [7:0] ESCAPE_BYTE = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } udm_state_e;

  // A data byte that collides with a protocol control code must be escaped
  function automatic logic needs_escape(input logic [7:0] b);
    return (b == SYNC_BYTE) || (b == ESCAPE_BYTE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 serializer for a single byte with valid/ready handshake.
//               Ready is raised in the final cycle of the stop bit so the
//               next frame follows without an idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 tx_o
);
  import udm_pkg::*;

  udm_state_e           state_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_q;
  logic                 tx_q;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 bit_end;
  logic                 load;

  // Divider values below 2 are clamped to a 2-clock bit time
  assign div_eff      = (divider_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divider_i;
  assign bit_end      = (cnt_q == DIV_WIDTH'(1));
  assign byte_ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign load         = byte_valid_i && byte_ready_o;
  assign tx_o         = tx_q;

  // Frame sequencer: bit counter counts down and reloads at each bit boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else if (load) begin
      state_q <= ST_START;
      div_q   <= div_eff;
      cnt_q   <= div_eff;
      shift_q <= byte_data_i;
      bit_q   <= '0;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            cnt_q   <= div_q;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= div_q;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/udm_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : udm_resp_tx
// Description : UDM response transmitter. Accepts a 32-bit word, sends it
//               LSB byte first as 8N1 UART frames, inserting an escape byte
//               before any data byte that equals a protocol control code.
// Revision    : 1.0 - initial release
// ============================================================================
module udm_resp_tx #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic                 word_req_i,
  input  logic [31:0]          word_data_i,
  output logic                 word_ack_o,
  output logic                 tx_o,
  output logic                 busy_o
);
  import udm_pkg::*;

  logic                 busy_q, busy_d;
  logic                 last_q, last_d;
  logic                 esc_q, esc_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  logic                 accept;
  logic [31:0]          cur_word;
  logic [DIV_WIDTH-1:0] cur_div;
  logic [7:0]           cur_byte;
  logic                 need_esc;
  logic [7:0]           send_byte;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 handshake;

  // The first byte goes out in the acceptance cycle, so it is taken straight
  // from the inputs; later bytes come from the latched copy.
  assign accept     = !busy_q && word_req_i && !rst_i;
  assign cur_word   = busy_q ? word_q : word_data_i;
  assign cur_div    = busy_q ? div_q : divider_i;
  assign need_esc   = needs_escape(cur_byte);
  assign send_byte  = (need_esc && !esc_q) ? ESCAPE_BYTE : cur_byte;
  assign byte_valid = accept || (busy_q && !last_q);
  assign handshake  = byte_valid && byte_ready;
  assign word_ack_o = accept;
  assign busy_o     = busy_q;

  // Select the byte addressed by the current byte index
  always_comb begin
    cur_byte = cur_word[7:0];
    case (idx_q)
      2'd0:    cur_byte = cur_word[7:0];
      2'd1:    cur_byte = cur_word[15:8];
      2'd2:    cur_byte = cur_word[23:16];
      default: cur_byte = cur_word[31:24];
    endcase
  end

  // Byte sequencing: escape flag, byte index and end-of-word detection
  always_comb begin
    busy_d = busy_q;
    last_d = last_q;
    esc_d  = esc_q;
    idx_d  = idx_q;
    word_d = word_q;
    div_d  = div_q;
    if (accept) begin
      busy_d = 1'b1;
      word_d = word_data_i;
      div_d  = divider_i;
    end
    if (handshake) begin
      if (need_esc && !esc_q) begin
        esc_d = 1'b1;
      end else begin
        esc_d = 1'b0;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          last_d = 1'b1;
        end
      end
    end
    // Final frame's stop bit ends in the cycle the serializer becomes ready
    if (busy_q && last_q && byte_ready) begin
      busy_d = 1'b0;
      last_d = 1'b0;
      esc_d  = 1'b0;
      idx_d  = 2'd0;
    end
  end

  // Sequencing state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      last_q <= 1'b0;
      esc_q  <= 1'b0;
      idx_q  <= 2'd0;
      word_q <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      last_q <= last_d;
      esc_q  <= esc_d;
      idx_q  <= idx_d;
      word_q <= word_d;
      div_q  <= div_d;
    end
  end

  uart_tx_byte #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_uart_tx_byte (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .divider_i   (cur_div),
    .byte_valid_i(byte_valid),
    .byte_data_i (send_byte),
    .byte_ready_o(byte_ready),
    .tx_o        (tx_o)
  );

endmodule
`default_nettype wire
